// File: rtl/score_packer_10.sv
// Serial-to-parallel packer: collects ten signed scores per frame into one flat
// vector for the argmax stage, with in_last framing checks.
module score_packer_10 #(
   parameter int unsigned BIT_WIDTH   = 8,
   parameter int unsigned INDEX_WIDTH = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BIT_WIDTH-1:0]      in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BIT_WIDTH*10-1:0]   out_vec,
   output logic                      frame_err,
   output logic [INDEX_WIDTH-1:0]    count
);

   localparam int unsigned LANES = 10;
   localparam logic [INDEX_WIDTH-1:0] LAST_LANE = INDEX_WIDTH'(LANES - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t                 state, state_d;
   logic [INDEX_WIDTH-1:0] count_d;
   logic                   valid_d;
   logic                   err_d;
   logic                   wr_en;
   logic                   accept;

   // A held frame releases the input side only when downstream takes it, so
   // the next frame's first beat can ride the same edge as the handoff.
   assign in_ready = (state == COLLECT) || out_ready;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= COLLECT;
         count     <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_d;
         count     <= count_d;
         out_valid <= valid_d;
         frame_err <= err_d;
      end
   end

   always_comb begin
      state_d = state;
      count_d = count;
      err_d   = 1'b0;
      wr_en   = 1'b0;

      if (state == HOLD && out_ready) begin
         state_d = COLLECT;
      end

      if (accept) begin
         wr_en = 1'b1;
         if (count == LAST_LANE) begin
            // Tenth beat always emits; a missing in_last flags the frame as long.
            state_d = HOLD;
            count_d = '0;
            err_d   = !in_last;
         end else if (in_last) begin
            state_d = COLLECT;
            count_d = '0;
            err_d   = 1'b1;
         end else begin
            count_d = count + INDEX_WIDTH'(1);
         end
      end

      valid_d = (state_d == HOLD);
   end

   // Lane storage doubles as the output register; unwritten lanes keep old data.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_vec <= '0;
      end else if (wr_en) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (count == INDEX_WIDTH'(i)) begin
               out_vec[i*BIT_WIDTH +: BIT_WIDTH] <= in_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_score_packer_10.sv
// Self-checking bench for score_packer_10: vector table, directed corner cases
// and random traffic against a frame-level queue model.
module tb_score_packer_10;

   localparam int unsigned BW = 8;
   localparam int unsigned IW = 4;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic [BW-1:0]  in_data = '0;
   logic           in_last = 1'b0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [BW*10-1:0] out_vec;
   logic           frame_err;
   logic [IW-1:0]  count;

   score_packer_10 #(.BIT_WIDTH(BW), .INDEX_WIDTH(IW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
      .frame_err(frame_err), .count(count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: elements of the frame in progress, last-written lane values,
   // and whether a finished frame is waiting for downstream.
   logic [BW-1:0] q[$];
   logic [BW-1:0] m_lanes[10];
   bit            m_hold;
   bit            m_err;

   task automatic chk(input string name, input logic [BW*10-1:0] act, input logic [BW*10-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [BW*10-1:0] m_vec();
      logic [BW*10-1:0] v;
      for (int i = 0; i < 10; i++) v[i*BW +: BW] = m_lanes[i];
      return v;
   endfunction

   task automatic m_reset();
      q.delete();
      for (int i = 0; i < 10; i++) m_lanes[i] = '0;
      m_hold = 1'b0;
      m_err  = 1'b0;
   endtask

   // One clock: drive, check ready, advance model, check registered outputs.
   task automatic cycle(input bit v, input logic [BW-1:0] d, input bit l, input bit ordy);
      bit acc;
      @(negedge clk);
      in_valid = v; in_data = d; in_last = l; out_ready = ordy;
      #1;
      chk("in_ready", 80'(in_ready), 80'(!m_hold || ordy));
      acc = v && (!m_hold || ordy);
      if (m_hold && ordy) m_hold = 1'b0;
      m_err = 1'b0;
      if (acc) begin
         m_lanes[q.size()] = d;
         q.push_back(d);
         if (q.size() == 10) begin
            m_hold = 1'b1;
            m_err  = !l;
            q.delete();
         end else if (l) begin
            m_err = 1'b1;
            q.delete();
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      chk("out_valid", 80'(out_valid), 80'(m_hold));
      chk("frame_err", 80'(frame_err), 80'(m_err));
      chk("count", 80'(count), 80'(q.size()));
      if (m_hold) chk("out_vec", out_vec, m_vec());
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0;
      @(posedge clk);
      #1;
      m_reset();
      chk("rst_out_valid", 80'(out_valid), 80'(0));
      chk("rst_out_vec", out_vec, 80'(0));
      chk("rst_frame_err", 80'(frame_err), 80'(0));
      chk("rst_count", 80'(count), 80'(0));
      @(negedge clk);
      reset = 1'b0;
   endtask

   typedef struct {
      bit               v;
      logic [BW-1:0]    d;
      bit               l;
      bit               ordy;
      bit               ev;
      bit               ee;
      logic [IW-1:0]    ec;
      logic [BW*10-1:0] ex;
   } vec_t;

   vec_t tbl[$];
   logic [BW*10-1:0] held, v1, v2;
   int t1, t2;

   initial begin
      m_reset();

      // Full frame 0..9, idle, short frame of 4, then a clean frame 0x20..0x29.
      for (int i = 0; i < 10; i++)
         tbl.push_back('{1'b1, BW'(i), i == 9, 1'b1, i == 9, 1'b0, IW'((i + 1) % 10),
                         80'h09080706050403020100});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 80'h0});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{1'b1, BW'(8'h40 + i), i == 3, 1'b1, 1'b0, i == 3, IW'((i + 1) % 4), 80'h0});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 80'h0});
      for (int i = 0; i < 10; i++)
         tbl.push_back('{1'b1, BW'(8'h20 + i), i == 9, 1'b1, i == 9, 1'b0, IW'((i + 1) % 10),
                         80'h29282726252423222120});
      tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 80'h0});

      do_reset();
      foreach (tbl[k]) begin
         cycle(tbl[k].v, tbl[k].d, tbl[k].l, tbl[k].ordy);
         chk("tbl_valid", 80'(out_valid), 80'(tbl[k].ev));
         chk("tbl_err", 80'(frame_err), 80'(tbl[k].ee));
         chk("tbl_count", 80'(count), 80'(tbl[k].ec));
         if (tbl[k].ev) chk("tbl_vec", out_vec, tbl[k].ex);
      end

      // Backpressure: held frame must not change while new data waits.
      for (int i = 0; i < 10; i++) cycle(1'b1, BW'(i), i == 9, 1'b0);
      held = out_vec;
      chk("hold_vec0", held, 80'h09080706050403020100);
      for (int k = 0; k < 5; k++) begin
         cycle(1'b1, BW'(8'hA0 + k), 1'b0, 1'b0);
         chk("hold_vec", out_vec, 80'h09080706050403020100);
         chk("hold_valid", 80'(out_valid), 80'(1));
      end
      cycle(1'b1, 8'h77, 1'b0, 1'b1);
      chk("release_count", 80'(count), 80'(1));
      chk("release_valid", 80'(out_valid), 80'(0));

      // Long frame: ten 0xFF without in_last.
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("long_vec", out_vec, {10{8'hFF}});
      chk("long_err", 80'(frame_err), 80'(1));
      chk("long_valid", 80'(out_valid), 80'(1));
      cycle(1'b1, 8'h55, 1'b0, 1'b1);
      chk("long_next_count", 80'(count), 80'(1));
      chk("long_next_err", 80'(frame_err), 80'(0));
      for (int i = 1; i < 10; i++) cycle(1'b1, BW'(8'h60 + i), i == 9, 1'b1);
      chk("long_next_vec", out_vec, 80'h69686766656463626155);

      // Back-to-back frames with continuous input.
      do_reset();
      t1 = -1; t2 = -1;
      for (int i = 0; i < 22; i++) begin
         if (i < 10)      cycle(1'b1, BW'(-128 + i), i == 9, 1'b1);
         else if (i < 20) cycle(1'b1, BW'(i), i == 19, 1'b1);
         else             cycle(1'b0, 8'h00, 1'b0, 1'b1);
         if (out_valid) begin
            if (t1 < 0) begin t1 = cyc; v1 = out_vec; end
            else if (t2 < 0) begin t2 = cyc; v2 = out_vec; end
         end
      end
      chk("b2b_gap", 80'(t2 - t1), 80'(10));
      chk("b2b_vec1", v1, 80'h89888786858483828180);
      chk("b2b_vec2", v2, 80'h13121110_0f0e0d0c0b0a);

      // Reset in the middle of a frame, then a fresh frame from lane 0.
      for (int i = 0; i < 6; i++) cycle(1'b1, BW'(8'hC0 + i), 1'b0, 1'b1);
      do_reset();
      for (int i = 0; i < 10; i++) cycle(1'b1, BW'(8'hD0 + i), i == 9, 1'b1);
      chk("post_rst_vec", out_vec, 80'hD9D8D7D6D5D4D3D2D1D0);

      // Random traffic against the model.
      for (int k = 0; k < 400; k++)
         cycle($urandom_range(0, 3) != 0, BW'($urandom), $urandom_range(0, 9) == 0,
               $urandom_range(0, 2) != 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
